// File: rtl/elevator_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// elevator_scan_ctrl_if
//   Bundles the call buttons and the car status outputs of the SCAN elevator
//   controller.
//   Ports (signals):
//     req        call buttons, level, one bit per floor (into controller)
//     cur_floor  current car floor
//     moving     car travelling between floors
//     dir_up     current/last travel direction (1 = up)
//     door_open  door phase active
//     arrive     one-cycle pulse after stopping at a requested floor
//     pending    latched outstanding calls
//   Modports: master = call panel / display side, slave = controller side.
// ---------------------------------------------------------------------------
interface elevator_scan_ctrl_if #(
  parameter int NUM_FLOORS = 8
);
  localparam int FLOOR_W = $clog2(NUM_FLOORS);

  logic [NUM_FLOORS-1:0] req;
  logic [FLOOR_W-1:0]    cur_floor;
  logic                  moving;
  logic                  dir_up;
  logic                  door_open;
  logic                  arrive;
  logic [NUM_FLOORS-1:0] pending;

  modport master (
    output req,
    input  cur_floor, moving, dir_up, door_open, arrive, pending
  );

  modport slave (
    input  req,
    output cur_floor, moving, dir_up, door_open, arrive, pending
  );
endinterface

// File: rtl/elevator_scan_ctrl.sv
// ---------------------------------------------------------------------------
// elevator_scan_ctrl
//   N-floor elevator controller: latches call requests, serves them in SCAN
//   order (keep going while calls remain ahead, then reverse), spends
//   TRAVEL_CYCLES per floor and DOOR_CYCLES per stop.
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous, active-high
//     bus    elevator_scan_ctrl_if.slave (req in; floor/status outs)
// ---------------------------------------------------------------------------
module elevator_scan_ctrl #(
  parameter int NUM_FLOORS    = 8,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  elevator_scan_ctrl_if.slave  bus
);

  localparam int FLOOR_W  = $clog2(NUM_FLOORS);
  localparam int TRAVEL_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DOOR_W   = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TRAVEL_W-1:0] TRAVEL_LAST = TRAVEL_W'(TRAVEL_CYCLES - 1);
  localparam logic [DOOR_W-1:0]   DOOR_LAST   = DOOR_W'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE,
    ST_DOOR
  } state_t;

  state_t                state_q,  state_d;
  logic [FLOOR_W-1:0]    floor_q,  floor_d;
  logic                  dir_up_q, dir_up_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [TRAVEL_W-1:0]   travel_q, travel_d;
  logic [DOOR_W-1:0]     door_q,   door_d;
  logic                  arrive_q, arrive_d;

  logic [NUM_FLOORS-1:0] cur_onehot;
  logic [NUM_FLOORS-1:0] latch_mask;
  logic                  req_here;
  logic                  any_above;
  logic                  any_below;
  logic [FLOOR_W-1:0]    floor_step;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_up_d  = dir_up_q;
    travel_d  = travel_q;
    door_d    = door_q;
    arrive_d  = 1'b0;

    cur_onehot = NUM_FLOORS'(1) << floor_q;
    req_here   = |(bus.req & cur_onehot);

    any_above = 1'b0;
    any_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_q[i] && (FLOOR_W'(i) > floor_q)) any_above = 1'b1;
      if (pending_q[i] && (FLOOR_W'(i) < floor_q)) any_below = 1'b1;
    end

    // A press at the car's own floor reopens/holds the door instead of being
    // queued, except while travelling: the car is already leaving that floor.
    latch_mask = (state_q == ST_MOVE) ? '1 : ~cur_onehot;
    pending_d  = pending_q | (bus.req & latch_mask);

    floor_step = dir_up_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (req_here) begin
          state_d = ST_DOOR;
          door_d  = '0;
        end else if (|pending_q) begin
          // SCAN: keep direction while calls remain ahead, else reverse.
          dir_up_d = dir_up_q ? any_above : !any_below;
          state_d  = ST_MOVE;
          travel_d = '0;
        end
      end

      ST_MOVE: begin
        if (travel_q == TRAVEL_LAST) begin
          travel_d = '0;
          floor_d  = floor_step;
          // Clearing after the OR above makes an arrival beat a same-edge press.
          if (pending_q[floor_step]) begin
            pending_d[floor_step] = 1'b0;
            state_d  = ST_DOOR;
            door_d   = '0;
            arrive_d = 1'b1;
          end
        end else begin
          travel_d = travel_q + TRAVEL_W'(1);
        end
      end

      ST_DOOR: begin
        if (req_here) begin
          door_d = '0;
        end else if (door_q == DOOR_LAST) begin
          state_d = ST_IDLE;
          door_d  = '0;
        end else begin
          door_d = door_q + DOOR_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      floor_q   <= '0;
      dir_up_q  <= 1'b1;
      pending_q <= '0;
      travel_q  <= '0;
      door_q    <= '0;
      arrive_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_up_q  <= dir_up_d;
      pending_q <= pending_d;
      travel_q  <= travel_d;
      door_q    <= door_d;
      arrive_q  <= arrive_d;
    end
  end

  assign bus.cur_floor = floor_q;
  assign bus.moving    = (state_q == ST_MOVE);
  assign bus.dir_up    = dir_up_q;
  assign bus.door_open = (state_q == ST_DOOR);
  assign bus.arrive    = arrive_q;
  assign bus.pending   = pending_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_elevator_scan_ctrl
//   Directed bench for elevator_scan_ctrl with 4 floors, 4 cycles per floor
//   and 3 door cycles. Inputs change 1 time unit after a rising edge and
//   outputs are sampled at the same point, so every check sees the state
//   produced by the edge just taken. Comments "eN" name edges relative to the
//   edge that sampled the first request of a scenario.
// ---------------------------------------------------------------------------
module tb_elevator_scan_ctrl;

  localparam int NF = 4;

  logic clk = 1'b0;
  logic reset;

  int n_cmp = 0;
  int n_err = 0;
  int arrive_seen = 0;

  elevator_scan_ctrl_if #(.NUM_FLOORS(NF)) bus ();

  elevator_scan_ctrl #(
    .NUM_FLOORS   (NF),
    .TRAVEL_CYCLES(4),
    .DOOR_CYCLES  (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; sample 1 unit after each and tally arrive pulses.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (bus.arrive) arrive_seen++;
    end
  endtask

  task automatic status(input string tag, input logic [31:0] floor,
                        input logic [31:0] mv, input logic [31:0] door,
                        input logic [31:0] arr, input logic [31:0] pend);
    check({tag, ".floor"},   32'(bus.cur_floor), floor);
    check({tag, ".moving"},  32'(bus.moving),    mv);
    check({tag, ".door"},    32'(bus.door_open), door);
    check({tag, ".arrive"},  32'(bus.arrive),    arr);
    check({tag, ".pending"}, 32'(bus.pending),   pend);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic press(input logic [NF-1:0] buttons);
    bus.req = buttons;
    tick(1);
    bus.req = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset   = 1'b1;
    bus.req = '0;

    // Reset held 3 cycles, then 10 idle cycles with no movement.
    tick(3);
    status("rst", 0, 0, 0, 0, 0);
    check("rst.dir_up", 32'(bus.dir_up), 1);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      status("idle", 0, 0, 0, 0, 0);
    end

    // Single call to floor 2 from floor 0.
    press(4'b0100);                          // e0
    status("s2.e0", 0, 0, 0, 0, 4'b0100);
    tick(1);                                 // e1
    status("s2.e1", 0, 1, 0, 0, 4'b0100);
    check("s2.e1.dir_up", 32'(bus.dir_up), 1);
    tick(4);                                 // e5
    status("s2.e5", 1, 1, 0, 0, 4'b0100);
    tick(3);                                 // e8
    status("s2.e8", 1, 1, 0, 0, 4'b0100);
    tick(1);                                 // e9
    status("s2.e9", 2, 0, 1, 1, 0);
    tick(1);                                 // e10
    status("s2.e10", 2, 0, 1, 0, 0);
    tick(1);                                 // e11
    status("s2.e11", 2, 0, 1, 0, 0);
    tick(1);                                 // e12
    status("s2.e12", 2, 0, 0, 0, 0);

    // Floor 0: call 3, then call 1 during the move -> intermediate stop.
    pulse_reset();
    status("s3.rst", 0, 0, 0, 0, 0);
    arrive_seen = 0;
    press(4'b1000);                          // e0
    tick(1);                                 // e1
    press(4'b0010);                          // e2
    status("s3.e2", 0, 1, 0, 0, 4'b1010);
    tick(3);                                 // e5
    status("s3.e5", 1, 0, 1, 1, 4'b1000);
    tick(2);                                 // e7
    status("s3.e7", 1, 0, 1, 0, 4'b1000);
    tick(1);                                 // e8
    status("s3.e8", 1, 0, 0, 0, 4'b1000);
    tick(1);                                 // e9
    status("s3.e9", 1, 1, 0, 0, 4'b1000);
    check("s3.e9.dir_up", 32'(bus.dir_up), 1);
    tick(4);                                 // e13: passes floor 2
    status("s3.e13", 2, 1, 0, 0, 4'b1000);
    tick(4);                                 // e17
    status("s3.e17", 3, 0, 1, 1, 0);
    check("s3.arrive_count", 32'(arrive_seen), 2);
    tick(3);                                 // e20
    status("s3.e20", 3, 0, 0, 0, 0);

    // Up toward 3 with calls at 3 and 0: serve 3, then reverse to 0.
    pulse_reset();
    press(4'b1000);                          // e0
    tick(9);                                 // e9
    status("s4.e9", 2, 1, 0, 0, 4'b1000);
    press(4'b0001);                          // e10
    status("s4.e10", 2, 1, 0, 0, 4'b1001);
    tick(3);                                 // e13
    status("s4.e13", 3, 0, 1, 1, 4'b0001);
    check("s4.e13.dir_up", 32'(bus.dir_up), 1);
    tick(3);                                 // e16
    status("s4.e16", 3, 0, 0, 0, 4'b0001);
    tick(1);                                 // e17
    status("s4.e17", 3, 1, 0, 0, 4'b0001);
    check("s4.e17.dir_up", 32'(bus.dir_up), 0);
    tick(4);                                 // e21
    status("s4.e21", 2, 1, 0, 0, 4'b0001);
    tick(8);                                 // e29
    status("s4.e29", 0, 0, 1, 1, 0);
    check("s4.e29.dir_up", 32'(bus.dir_up), 0);
    tick(3);                                 // e32
    status("s4.e32", 0, 0, 0, 0, 0);

    // Go to floor 1 (reverses to up), then door reopen and re-press hold.
    press(4'b0010);                          // f0
    tick(1);                                 // f1
    check("s5.f1.dir_up", 32'(bus.dir_up), 1);
    tick(4);                                 // f5
    status("s5.f5", 1, 0, 1, 1, 0);
    tick(3);                                 // f8
    status("s5.f8", 1, 0, 0, 0, 0);
    press(4'b0010);                          // f9: reopen, no arrive
    status("s5.f9", 1, 0, 1, 0, 0);
    tick(2);                                 // f11: door's last cycle
    status("s5.f11", 1, 0, 1, 0, 0);
    press(4'b0010);                          // f12: counter restarts
    status("s5.f12", 1, 0, 1, 0, 0);
    tick(1);                                 // f13
    status("s5.f13", 1, 0, 1, 0, 0);
    tick(1);                                 // f14
    status("s5.f14", 1, 0, 1, 0, 0);
    tick(1);                                 // f15
    status("s5.f15", 1, 0, 0, 0, 0);

    // Reset while travelling from floor 1 toward 2 aborts without homing.
    press(4'b1000);                          // g0
    tick(2);                                 // g2
    status("s6.g2", 1, 1, 0, 0, 4'b1000);
    pulse_reset();                           // g3
    status("s6.g3", 0, 0, 0, 0, 0);
    check("s6.g3.dir_up", 32'(bus.dir_up), 1);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      status("s6.after", 0, 0, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
